// File: rtl/inst_sram_responder_if.sv
// rtl/inst_sram_responder_if.sv - inst_sram port bundle between the fetch stage and the SRAM responder
interface inst_sram_responder_if;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        addr_err;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  modport master (
    output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
    input  inst_sram_rdata, addr_err, rd_cnt, wr_cnt
  );

  modport slave (
    input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
    output inst_sram_rdata, addr_err, rd_cnt, wr_cnt
  );
endinterface

// File: rtl/inst_sram_responder.sv
// rtl/inst_sram_responder.sv - single-port word SRAM responder, one-cycle read latency, byte-lane write-first
// Access counters rd_cnt/wr_cnt are built only when INST_SRAM_PERF_CNT_EN is defined.
module inst_sram_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h1c00_0000,
  parameter int unsigned DEPTH_WORDS = 4096
) (
  input logic                  clk,
  input logic                  resetn,
  inst_sram_responder_if.slave sram
);
  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [31:0]      off;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             is_wr;
  logic [31:0]      old_word;
  logic [31:0]      merged;
  logic [31:0]      rdata_q;
  logic             addr_err_q;

  // Offset wraps, so addresses below ADDR_BASE land far out of range.
  assign off      = sram.inst_sram_addr - ADDR_BASE;
  assign in_range = {1'b0, off} < SPAN_BYTES;
  assign idx      = off[IDX_W+1:2];
  assign is_wr    = |sram.inst_sram_we;
  assign old_word = mem[idx];

  // With we all zero the merged word is the stored word, so reads share this path.
  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (sram.inst_sram_we[i]) begin
        merged[8*i +: 8] = sram.inst_sram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && sram.inst_sram_en && in_range && is_wr) begin
      mem[idx] <= merged;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q    <= '0;
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= sram.inst_sram_en && !in_range;
      if (sram.inst_sram_en) begin
        rdata_q <= in_range ? merged : 32'h0;
      end
    end
  end

  assign sram.inst_sram_rdata = rdata_q;
  assign sram.addr_err        = addr_err_q;

`ifdef INST_SRAM_PERF_CNT_EN
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (sram.inst_sram_en && in_range) begin
      if (!is_wr && rd_cnt_q != 32'hFFFF_FFFF) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (is_wr && wr_cnt_q != 32'hFFFF_FFFF) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign sram.rd_cnt = rd_cnt_q;
  assign sram.wr_cnt = wr_cnt_q;
`else
  assign sram.rd_cnt = 32'h0;
  assign sram.wr_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_inst_sram_responder.sv
// tb/tb_inst_sram_responder.sv - scoreboard bench for inst_sram_responder
module tb_inst_sram_responder;
  localparam logic [31:0] BASE  = 32'h1c00_0000;
  localparam int          DEPTH = 4096;

  logic clk;
  logic resetn;
  inst_sram_responder_if bus();

  inst_sram_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .sram   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec  = 0;
  int          n_fail = 0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_rdata = 32'h0;
  logic [31:0] model_rd = 32'h0;
  logic [31:0] model_wr = 32'h0;
  logic [31:0] exp_rdata_q [$];
  logic        exp_err_q [$];

  function automatic logic [31:0] exp_rd();
`ifdef INST_SRAM_PERF_CNT_EN
    return model_rd;
`else
    return 32'h0;
`endif
  endfunction

  function automatic logic [31:0] exp_wr();
`ifdef INST_SRAM_PERF_CNT_EN
    return model_wr;
`else
    return 32'h0;
`endif
  endfunction

  task automatic preload(input int idx, input logic [31:0] val);
    dut.mem[idx]   = val;
    model_mem[idx] = val;
  endtask

  // Drive one cycle of stimulus, push the expected response, and return #1 after the edge.
  task automatic drive(input logic en, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] off;
    logic [31:0] nw;
    logic        inr;
    int          idx;
    off = addr - BASE;
    inr = off < 32'(DEPTH * 4);
    idx = int'(off[13:2]);
    bus.inst_sram_en    = en;
    bus.inst_sram_we    = we;
    bus.inst_sram_addr  = addr;
    bus.inst_sram_wdata = wdata;
    if (en) begin
      if (inr) begin
        nw = model_mem[idx];
        for (int i = 0; i < 4; i++) if (we[i]) nw[8*i +: 8] = wdata[8*i +: 8];
        if (we != 4'b0) begin
          model_mem[idx] = nw;
          if (model_wr != 32'hFFFF_FFFF) model_wr = model_wr + 1;
        end else if (model_rd != 32'hFFFF_FFFF) begin
          model_rd = model_rd + 1;
        end
        model_rdata = nw;
      end else begin
        model_rdata = 32'h0;
      end
    end
    exp_rdata_q.push_back(model_rdata);
    exp_err_q.push_back(en && !inr);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.inst_sram_en = 1'b0; bus.inst_sram_we = 4'h0;
    bus.inst_sram_addr = 32'h1bff_fffc; bus.inst_sram_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (bus.inst_sram_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", bus.inst_sram_rdata); end
    n_vec++; if (bus.addr_err !== 1'b0) begin n_fail++; $display("FAIL reset_addr_err got %b want 0", bus.addr_err); end
    n_vec++; if (bus.rd_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_rd_cnt got %h want 0", bus.rd_cnt); end
    n_vec++; if (bus.wr_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_wr_cnt got %h want 0", bus.wr_cnt); end
    preload(0, 32'h0280_0421);
    preload(1, 32'h1234_5678);
    preload(2, 32'hAABB_CCDD);
    preload(4, 32'h0BAD_C0DE);
    preload(4095, 32'hCAFE_F00D);
    resetn = 1'b1;
  endtask

  task automatic test_basic_read();
    logic [31:0] want [2];
    logic [31:0] er;
    logic        ee;
    want[0] = 32'h0280_0421;
    want[1] = 32'h1234_5678;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 4'h0, BASE + 32'(4 * k), 32'h0);
      er = exp_rdata_q.pop_front(); ee = exp_err_q.pop_front();
      n_vec++; if (bus.inst_sram_rdata !== want[k] || er !== want[k]) begin n_fail++; $display("FAIL basic_read[%0d] got %h want %h", k, bus.inst_sram_rdata, want[k]); end
      n_vec++; if (bus.addr_err !== ee) begin n_fail++; $display("FAIL basic_err[%0d] got %b want %b", k, bus.addr_err, ee); end
    end
    n_vec++; if (bus.rd_cnt !== exp_rd()) begin n_fail++; $display("FAIL basic_rd_cnt got %h want %h", bus.rd_cnt, exp_rd()); end
  endtask

  task automatic test_byte_lane();
    logic [31:0] er;
    logic        ee;
    drive(1'b1, 4'b0101, 32'h1c00_0008, 32'h1122_3344);
    er = exp_rdata_q.pop_front(); ee = exp_err_q.pop_front();
    n_vec++; if (bus.inst_sram_rdata !== 32'hAA22_CC44) begin n_fail++; $display("FAIL lane_write got %h want aa22cc44", bus.inst_sram_rdata); end
    drive(1'b1, 4'h0, 32'h1c00_0008, 32'h0);
    er = exp_rdata_q.pop_front(); ee = exp_err_q.pop_front();
    n_vec++; if (bus.inst_sram_rdata !== er) begin n_fail++; $display("FAIL lane_readback got %h want %h", bus.inst_sram_rdata, er); end
    n_vec++; if (bus.wr_cnt !== exp_wr()) begin n_fail++; $display("FAIL lane_wr_cnt got %h want %h", bus.wr_cnt, exp_wr()); end
  endtask

  task automatic test_hold_idle();
    logic [31:0] er;
    logic        ee;
    drive(1'b1, 4'h0, 32'h1c00_0004, 32'h0);
    er = exp_rdata_q.pop_front(); ee = exp_err_q.pop_front();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 4'hF, 32'h1c00_4000, 32'hFFFF_FFFF);
      er = exp_rdata_q.pop_front(); ee = exp_err_q.pop_front();
      n_vec++; if (bus.inst_sram_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL idle_hold[%0d] got %h want 12345678", k, bus.inst_sram_rdata); end
      n_vec++; if (bus.addr_err !== 1'b0) begin n_fail++; $display("FAIL idle_err[%0d] got %b want 0", k, bus.addr_err); end
    end
  endtask

  task automatic test_range();
    logic [31:0] addrs [5];
    logic [3:0]  wes [5];
    logic [31:0] er;
    logic        ee;
    logic [31:0] rd_before;
    addrs[0] = 32'h1c00_3ffc; wes[0] = 4'h0;
    addrs[1] = 32'h1c00_4000; wes[1] = 4'h0;
    addrs[2] = 32'h1bff_fffc; wes[2] = 4'hF;
    addrs[3] = 32'h1bff_fffc; wes[3] = 4'h0;
    addrs[4] = 32'h1c00_3ffc; wes[4] = 4'h0;
    rd_before = exp_rd();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, wes[k], addrs[k], 32'hDEAD_BEEF);
      er = exp_rdata_q.pop_front(); ee = exp_err_q.pop_front();
      n_vec++; if (bus.inst_sram_rdata !== er) begin n_fail++; $display("FAIL range_rdata[%0d] got %h want %h", k, bus.inst_sram_rdata, er); end
      n_vec++; if (bus.addr_err !== ee) begin n_fail++; $display("FAIL range_err[%0d] got %b want %b", k, bus.addr_err, ee); end
      if (k == 0) begin
        n_vec++; if (bus.rd_cnt !== exp_rd()) begin n_fail++; $display("FAIL range_rd_cnt got %h want %h", bus.rd_cnt, exp_rd()); end
      end
    end
    n_vec++; if (bus.inst_sram_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL range_mem_kept got %h want cafef00d", bus.inst_sram_rdata); end
`ifdef INST_SRAM_PERF_CNT_EN
    n_vec++; if (bus.rd_cnt !== rd_before + 32'd2) begin n_fail++; $display("FAIL range_rd_total got %h want %h", bus.rd_cnt, rd_before + 32'd2); end
`else
    n_vec++; if (bus.rd_cnt !== rd_before) begin n_fail++; $display("FAIL range_rd_total got %h want %h", bus.rd_cnt, rd_before); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] er;
    logic        ee;
    logic [31:0] a;
    logic [3:0]  w;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 4'hF, BASE + 32'(4 * (8 + k)), $urandom);
      er = exp_rdata_q.pop_front(); ee = exp_err_q.pop_front();
      n_vec++; if (bus.inst_sram_rdata !== er) begin n_fail++; $display("FAIL b2b_fill[%0d] got %h want %h", k, bus.inst_sram_rdata, er); end
    end
    for (int k = 0; k < 24; k++) begin
      a = BASE + 32'(4 * (8 + $urandom_range(0, 7)));
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      drive(1'b1, w, a, $urandom);
      er = exp_rdata_q.pop_front(); ee = exp_err_q.pop_front();
      n_vec++; if (bus.inst_sram_rdata !== er || bus.addr_err !== ee) begin n_fail++; $display("FAIL b2b_mix[%0d] got %h/%b want %h/%b", k, bus.inst_sram_rdata, bus.addr_err, er, ee); end
    end
    n_vec++; if (bus.rd_cnt !== exp_rd() || bus.wr_cnt !== exp_wr()) begin n_fail++; $display("FAIL b2b_cnt got %h/%h want %h/%h", bus.rd_cnt, bus.wr_cnt, exp_rd(), exp_wr()); end
  endtask

  task automatic test_async_reset();
    logic [31:0] er;
    logic        ee;
    drive(1'b1, 4'h0, 32'h1c00_0004, 32'h0);
    er = exp_rdata_q.pop_front(); ee = exp_err_q.pop_front();
    n_vec++; if (bus.inst_sram_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL arst_pre got %h want 12345678", bus.inst_sram_rdata); end
    bus.inst_sram_en = 1'b1; bus.inst_sram_we = 4'hF;
    bus.inst_sram_addr = 32'h1c00_0010; bus.inst_sram_wdata = 32'h5555_AAAA;
    #3;
    resetn = 1'b0;
    #1;
    n_vec++; if (bus.inst_sram_rdata !== 32'h0) begin n_fail++; $display("FAIL arst_rdata got %h want 0", bus.inst_sram_rdata); end
    n_vec++; if (bus.addr_err !== 1'b0) begin n_fail++; $display("FAIL arst_err got %b want 0", bus.addr_err); end
    n_vec++; if (bus.rd_cnt !== 32'h0 || bus.wr_cnt !== 32'h0) begin n_fail++; $display("FAIL arst_cnt got %h/%h want 0/0", bus.rd_cnt, bus.wr_cnt); end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    model_rdata = 32'h0; model_rd = 32'h0; model_wr = 32'h0;
    drive(1'b1, 4'h0, 32'h1c00_0010, 32'h0);
    er = exp_rdata_q.pop_front(); ee = exp_err_q.pop_front();
    n_vec++; if (bus.inst_sram_rdata !== 32'h0BAD_C0DE) begin n_fail++; $display("FAIL arst_mem_kept got %h want 0badc0de", bus.inst_sram_rdata); end
    n_vec++; if (bus.rd_cnt !== exp_rd()) begin n_fail++; $display("FAIL arst_rd_cnt got %h want %h", bus.rd_cnt, exp_rd()); end
  endtask

  task automatic test_counters();
    logic [31:0] er;
    logic        ee;
`ifdef INST_SRAM_PERF_CNT_EN
    dut.rd_cnt_q = 32'hFFFF_FFFE;
    model_rd     = 32'hFFFF_FFFE;
`endif
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 4'h0, BASE, 32'h0);
      er = exp_rdata_q.pop_front(); ee = exp_err_q.pop_front();
      n_vec++; if (bus.inst_sram_rdata !== 32'h0280_0421) begin n_fail++; $display("FAIL cnt_rdata[%0d] got %h want 02800421", k, bus.inst_sram_rdata); end
`ifdef INST_SRAM_PERF_CNT_EN
      n_vec++; if (bus.rd_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cnt_sat[%0d] got %h want ffffffff", k, bus.rd_cnt); end
`else
      n_vec++; if (bus.rd_cnt !== 32'h0 || bus.wr_cnt !== 32'h0) begin n_fail++; $display("FAIL cnt_tied[%0d] got %h/%h want 0/0", k, bus.rd_cnt, bus.wr_cnt); end
`endif
    end
    drive(1'b0, 4'h0, BASE, 32'h0);
    er = exp_rdata_q.pop_front(); ee = exp_err_q.pop_front();
    n_vec++; if (exp_rdata_q.size() != 0 || bus.inst_sram_rdata !== er) begin n_fail++; $display("FAIL sb_drain got %h want %h (left %0d)", bus.inst_sram_rdata, er, exp_rdata_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_byte_lane();
    test_hold_idle();
    test_range();
    test_back_to_back();
    test_async_reset();
    test_counters();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
